// File: rtl/conv_window_router.sv
// Convolution window router: fetches packed activation words from a 1-cycle SRAM
// and emits one im2col element per output row per beat, with zero padding and backpressure.
module conv_window_router #(
    parameter int ROW_COUNT       = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int SRAM_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_K           = 7
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [ADDR_WIDTH-1:0]           i_start_addr,
    input  logic [ADDR_WIDTH-1:0]           i_i_size,
    input  logic [ADDR_WIDTH-1:0]           i_o_size,
    input  logic [$clog2(MAX_K+1)-1:0]      i_k_size,
    input  logic [1:0]                      i_stride,
    input  logic [1:0]                      i_pad,
    input  logic [ADDR_WIDTH-1:0]           i_channels,
    input  logic [ADDR_WIDTH-1:0]           i_plane_words,
    output logic                            o_sram_read_en,
    output logic [ADDR_WIDTH-1:0]           o_sram_read_addr,
    input  logic [SRAM_DATA_WIDTH-1:0]      i_sram_data,
    output logic [ROW_COUNT*DATA_WIDTH-1:0] o_data,
    output logic [ROW_COUNT-1:0]            o_data_valid,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_last,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int ELEMS  = SRAM_DATA_WIDTH / DATA_WIDTH;
    localparam int LANE_W = $clog2(ELEMS);
    localparam int ROW_W  = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
    localparam int KW     = $clog2(MAX_K + 1);
    localparam int AW     = ADDR_WIDTH;
    localparam int SW     = ADDR_WIDTH + 3;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT, DONE} state_e;

    state_e state_q, state_d;

    logic [AW-1:0]          startAddr_q, iSize_q, oSize_q, channels_q, planeWords_q;
    logic [KW-1:0]          kSize_q, kx_q, ky_q;
    logic [1:0]             stride_q, pad_q;
    logic [AW-1:0]          chan_q, chanBase_q;
    logic [AW-1:0]          grpOy_q, grpOx_q, rowOy_q, rowOx_q;
    logic signed [SW-1:0]   grpIyBase_q, grpIxBase_q, rowIyBase_q, rowIxBase_q;
    logic [ROW_W-1:0]       rowCnt_q, capRow_q;
    logic                   capValid_q;
    logic [LANE_W-1:0]      capLane_q;
    logic [DATA_WIDTH-1:0]  rowData_q [ROW_COUNT];
    logic [ROW_COUNT-1:0]   rowValid_q;

    logic signed [SW-1:0]   curIy, curIx, iSizeExt, strideExt, padNeg;
    logic                   rowActive, rowPadded, doRead, fetchLast, kernelLast, groupLast;
    logic [2*AW-1:0]        idxFull;
    logic [AW-1:0]          wordOff;

    // Row walker: the iy/ix bases already hold oy*stride-pad and ox*stride-pad,
    // so the only multiply left is the row-major flattening by the input size.
    always_comb begin
        iSizeExt   = $signed({3'b000, iSize_q});
        strideExt  = $signed({{(SW-2){1'b0}}, stride_q});
        padNeg     = -$signed({{(SW-2){1'b0}}, pad_q});
        curIy      = rowIyBase_q + $signed({{(SW-KW){1'b0}}, ky_q});
        curIx      = rowIxBase_q + $signed({{(SW-KW){1'b0}}, kx_q});
        rowActive  = rowOy_q < oSize_q;
        rowPadded  = curIy[SW-1] || (curIy >= iSizeExt) || curIx[SW-1] || (curIx >= iSizeExt);
        idxFull    = {{AW{1'b0}}, curIy[AW-1:0]} * {{AW{1'b0}}, iSize_q}
                   + {{AW{1'b0}}, curIx[AW-1:0]};
        wordOff    = AW'(idxFull >> LANE_W);
        doRead     = (state_q == FETCH) && rowActive && !rowPadded;
        fetchLast  = rowCnt_q == ROW_W'(ROW_COUNT - 1);
        kernelLast = (kx_q == kSize_q - KW'(1)) && (ky_q == kSize_q - KW'(1))
                   && (chan_q == channels_q - AW'(1));
        groupLast  = rowOy_q >= oSize_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = FETCH;
            FETCH:   if (fetchLast) state_d = CAPTURE;
            CAPTURE: state_d = EMIT;
            EMIT:    if (i_ready) state_d = (kernelLast && groupLast) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_sram_read_en   = doRead;
        o_sram_read_addr = doRead ? startAddr_q + chanBase_q + wordOff : '0;
        o_valid          = state_q == EMIT;
        o_last           = (state_q == EMIT) && kernelLast;
        o_busy           = (state_q == FETCH) || (state_q == CAPTURE) || (state_q == EMIT);
        o_done           = state_q == DONE;
        o_data_valid     = rowValid_q;
        o_data           = '0;
        for (int r = 0; r < ROW_COUNT; r++) o_data[r*DATA_WIDTH +: DATA_WIDTH] = rowData_q[r];
    end

    // The read issued in FETCH cycle r lands one cycle later, in FETCH r+1 or CAPTURE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            startAddr_q  <= '0;  iSize_q     <= '0;  oSize_q     <= '0;
            channels_q   <= '0;  planeWords_q <= '0; kSize_q     <= '0;
            stride_q     <= '0;  pad_q       <= '0;  kx_q        <= '0;
            ky_q         <= '0;  chan_q      <= '0;  chanBase_q  <= '0;
            grpOy_q      <= '0;  grpOx_q     <= '0;  rowOy_q     <= '0;
            rowOx_q      <= '0;  grpIyBase_q <= '0;  grpIxBase_q <= '0;
            rowIyBase_q  <= '0;  rowIxBase_q <= '0;  rowCnt_q    <= '0;
            capRow_q     <= '0;  capValid_q  <= 1'b0; capLane_q  <= '0;
            rowValid_q   <= '0;
            for (int r = 0; r < ROW_COUNT; r++) rowData_q[r] <= '0;
        end else begin
            capValid_q <= doRead;
            capRow_q   <= rowCnt_q;
            capLane_q  <= idxFull[LANE_W-1:0];
            if (capValid_q) rowData_q[capRow_q] <= i_sram_data[capLane_q*DATA_WIDTH +: DATA_WIDTH];
            case (state_q)
                IDLE: if (i_start) begin
                    startAddr_q  <= i_start_addr;  iSize_q    <= i_i_size;
                    oSize_q      <= i_o_size;      kSize_q    <= i_k_size;
                    stride_q     <= i_stride;      pad_q      <= i_pad;
                    channels_q   <= i_channels;    planeWords_q <= i_plane_words;
                    kx_q         <= '0;  ky_q    <= '0;  chan_q  <= '0;  chanBase_q <= '0;
                    grpOy_q      <= '0;  grpOx_q <= '0;  rowOy_q <= '0;  rowOx_q    <= '0;
                    grpIyBase_q  <= -$signed({{(SW-2){1'b0}}, i_pad});
                    grpIxBase_q  <= -$signed({{(SW-2){1'b0}}, i_pad});
                    rowIyBase_q  <= -$signed({{(SW-2){1'b0}}, i_pad});
                    rowIxBase_q  <= -$signed({{(SW-2){1'b0}}, i_pad});
                    rowCnt_q     <= '0;
                end
                FETCH: begin
                    if (!doRead) rowData_q[rowCnt_q] <= '0;
                    rowValid_q[rowCnt_q] <= rowActive;
                    rowCnt_q <= fetchLast ? '0 : rowCnt_q + ROW_W'(1);
                    if (rowOx_q == oSize_q - AW'(1)) begin
                        rowOx_q     <= '0;
                        rowOy_q     <= rowOy_q + AW'(1);
                        rowIxBase_q <= padNeg;
                        rowIyBase_q <= rowIyBase_q + strideExt;
                    end else begin
                        rowOx_q     <= rowOx_q + AW'(1);
                        rowIxBase_q <= rowIxBase_q + strideExt;
                    end
                end
                EMIT: if (i_ready) begin
                    // After FETCH the row walker sits on the first pixel of the next group.
                    if (kernelLast) begin
                        kx_q <= '0;  ky_q <= '0;  chan_q <= '0;  chanBase_q <= '0;
                        grpOy_q     <= rowOy_q;      grpOx_q     <= rowOx_q;
                        grpIyBase_q <= rowIyBase_q;  grpIxBase_q <= rowIxBase_q;
                    end else begin
                        rowOy_q     <= grpOy_q;      rowOx_q     <= grpOx_q;
                        rowIyBase_q <= grpIyBase_q;  rowIxBase_q <= grpIxBase_q;
                        if (kx_q != kSize_q - KW'(1)) begin
                            kx_q <= kx_q + KW'(1);
                        end else begin
                            kx_q <= '0;
                            if (ky_q != kSize_q - KW'(1)) begin
                                ky_q <= ky_q + KW'(1);
                            end else begin
                                ky_q       <= '0;
                                chan_q     <= chan_q + AW'(1);
                                chanBase_q <= chanBase_q + planeWords_q;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_router.sv
// Self-checking bench for conv_window_router: directed jobs from known images plus
// randomized configurations, all compared against a plain-arithmetic im2col model.
module tb_conv_window_router;

    localparam int R     = 4;
    localparam int DW    = 8;
    localparam int SDW   = 64;
    localparam int AW    = 10;
    localparam int MAXK  = 7;
    localparam int ELEMS = SDW / DW;

    logic              i_clk, i_rst, i_start, i_ready;
    logic [AW-1:0]     i_start_addr, i_i_size, i_o_size, i_channels, i_plane_words;
    logic [2:0]        i_k_size;
    logic [1:0]        i_stride, i_pad;
    logic              o_sram_read_en;
    logic [AW-1:0]     o_sram_read_addr;
    logic [SDW-1:0]    sramData;
    logic [R*DW-1:0]   o_data;
    logic [R-1:0]      o_data_valid;
    logic              o_valid, o_last, o_busy, o_done;

    logic [SDW-1:0]    mem [0:1023];
    logic [AW-1:0]     readQ[$];
    logic [AW-1:0]     expAddrQ[$];
    int                doneCount = 0;
    int                vectors = 0;
    int                miscompares = 0;
    int                cfgI, cfgO, cfgK, cfgS, cfgP, cfgCh, cfgPlane, cfgStart;
    logic [R*DW-1:0]   expData, firstData, beat4Data;
    logic [R-1:0]      expMask, firstMask, lastMask;
    bit                hung = 0;

    conv_window_router #(
        .ROW_COUNT(R), .DATA_WIDTH(DW), .SRAM_DATA_WIDTH(SDW), .ADDR_WIDTH(AW), .MAX_K(MAXK)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_start_addr(i_start_addr),
        .i_i_size(i_i_size), .i_o_size(i_o_size), .i_k_size(i_k_size), .i_stride(i_stride),
        .i_pad(i_pad), .i_channels(i_channels), .i_plane_words(i_plane_words),
        .o_sram_read_en(o_sram_read_en), .o_sram_read_addr(o_sram_read_addr),
        .i_sram_data(sramData), .o_data(o_data), .o_data_valid(o_data_valid),
        .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_sram_read_en) sramData <= mem[o_sram_read_addr];

    always @(negedge i_clk) begin
        if (o_sram_read_en) readQ.push_back(o_sram_read_addr);
        if (o_done) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge i_clk);
        i_start_addr  = AW'(cfgStart);
        i_i_size      = AW'(cfgI);
        i_o_size      = AW'(cfgO);
        i_k_size      = 3'(cfgK);
        i_stride      = 2'(cfgS);
        i_pad         = 2'(cfgP);
        i_channels    = AW'(cfgCh);
        i_plane_words = AW'(cfgPlane);
        i_start       = 1'b1;
    endtask

    // Reference im2col: pixel/coordinate arithmetic straight from the window definition.
    task automatic modelBeat(input int g, input int c, input int ky, input int kx);
        expData = '0;
        expMask = '0;
        expAddrQ.delete();
        for (int r = 0; r < R; r++) begin
            int p, oy, ox, iy, ix, idx, addr;
            logic [SDW-1:0] w;
            p = g * R + r;
            if (p < cfgO * cfgO) begin
                expMask[r] = 1'b1;
                oy = p / cfgO;
                ox = p % cfgO;
                iy = oy * cfgS + ky - cfgP;
                ix = ox * cfgS + kx - cfgP;
                if (iy >= 0 && iy < cfgI && ix >= 0 && ix < cfgI) begin
                    idx  = iy * cfgI + ix;
                    addr = (cfgStart + c * cfgPlane + idx / ELEMS) % 1024;
                    w    = mem[addr];
                    expData[r*DW +: DW] = w[(idx % ELEMS)*DW +: DW];
                    expAddrQ.push_back(AW'(addr));
                end
            end
        end
    endtask

    task automatic runJob(input int holdMode);
        int groups, beat, hold, cyc, dc0;
        bit expLast;
        if (hung) return;
        groups = (cfgO * cfgO + R - 1) / R;
        beat   = 0;
        dc0    = doneCount;
        i_ready = 1'b0;
        readQ.delete();
        applyStimulus();
        for (int g = 0; g < groups; g++)
        for (int c = 0; c < cfgCh; c++)
        for (int ky = 0; ky < cfgK; ky++)
        for (int kx = 0; kx < cfgK; kx++) begin
            modelBeat(g, c, ky, kx);
            expLast = (c == cfgCh - 1) && (ky == cfgK - 1) && (kx == cfgK - 1);
            hold = (holdMode == 0) ? 0 : ((beat == 0) ? 5 : int'($urandom_range(0, 3)));
            cyc = 0;
            do begin
                @(negedge i_clk);
                cyc++;
                i_start = 1'b0;
                i_ready = (hold == 0);
            end while (!o_valid && cyc < 64);
            checkOutput("beat_valid", 64'(o_valid), 64'd1);
            if (!o_valid) begin
                $display("[TB] FAIL beat_timeout: no o_valid within 64 cycles, got 0 required 1");
                hung = 1;
                return;
            end
            checkOutput("beat_latency", 64'(cyc), 64'(R + 2));
            checkOutput("beat_data", 64'(o_data), 64'(expData));
            checkOutput("beat_mask", 64'(o_data_valid), 64'(expMask));
            checkOutput("beat_last", 64'(o_last), 64'(expLast));
            checkOutput("beat_busy_done", {62'd0, o_busy, o_done}, 64'b10);
            checkOutput("beat_read_count", 64'(readQ.size()), 64'(expAddrQ.size()));
            for (int i = 0; i < expAddrQ.size() && i < readQ.size(); i++)
                checkOutput("beat_read_addr", 64'(readQ[i]), 64'(expAddrQ[i]));
            readQ.delete();
            if (beat == 0) begin firstData = o_data; firstMask = o_data_valid; end
            if (beat == 4) beat4Data = o_data;
            lastMask = o_data_valid;
            for (int h = 0; h < hold; h++) begin
                @(negedge i_clk);
                checkOutput("hold_data", 64'(o_data), 64'(expData));
                checkOutput("hold_valid_noread", {62'd0, o_valid, o_sram_read_en}, 64'b10);
            end
            i_ready = 1'b1;
            beat++;
        end
        @(negedge i_clk);
        checkOutput("done_state", {61'd0, o_done, o_busy, o_valid}, 64'b100);
        i_ready = 1'b0;
        @(negedge i_clk);
        checkOutput("done_cleared", 64'(o_done), 64'd0);
        @(negedge i_clk);
        checkOutput("done_pulses", 64'(doneCount - dc0), 64'd1);
    endtask

    task automatic fillLinear();
        for (int w = 0; w < 1024; w++)
            for (int l = 0; l < ELEMS; l++) mem[w][l*DW +: DW] = DW'(w * ELEMS + l + 1);
    endtask

    task automatic setCfg(input int isz, input int k, input int s, input int pd,
                          input int ch, input int plane, input int start);
        cfgI = isz; cfgK = k; cfgS = s; cfgP = pd; cfgCh = ch; cfgPlane = plane; cfgStart = start;
        cfgO = (isz + 2 * pd - k) / s + 1;
    endtask

    initial begin
        int dc0;
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0;
        i_start_addr = '0; i_i_size = '0; i_o_size = '0; i_k_size = '0;
        i_stride = '0; i_pad = '0; i_channels = '0; i_plane_words = '0;
        sramData = '0;
        repeat (3) @(negedge i_clk);
        checkOutput("reset_outputs",
            64'({o_valid, o_busy, o_done, o_last, o_sram_read_en, o_sram_read_addr, o_data_valid, o_data}), 64'd0);
        i_rst = 1'b0;

        fillLinear();
        setCfg(4, 3, 1, 1, 1, 16, 0);
        runJob(0);
        checkOutput("pad_beat0_data", 64'(firstData), 64'd0);
        checkOutput("pad_beat0_mask", 64'(firstMask), 64'hF);
        checkOutput("pad_beat4_data", 64'(beat4Data), 64'h04030201);

        setCfg(5, 3, 1, 0, 1, 32, 0);
        runJob(1);
        checkOutput("tail_group_mask", 64'(lastMask), 64'b0001);

        setCfg(8, 3, 2, 0, 1, 64, 0);
        runJob(0);
        checkOutput("stride2_beat0_data", 64'(firstData), 64'h11050301);

        setCfg(4, 3, 1, 0, 2, 2, 0);
        runJob(0);

        for (int w = 0; w < 1024; w++) mem[w] = {$urandom, $urandom};
        setCfg(7, 7, 1, 0, 1, 5, 1020);
        runJob(1);
        for (int j = 0; j < 4; j++) begin
            int isz, k;
            isz = int'($urandom_range(3, 6));
            k   = int'($urandom_range(1, isz));
            setCfg(isz, k, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 2)), int'($urandom_range(0, 20)), int'($urandom_range(0, 1023)));
            runJob(j % 2);
        end

        // Abort a job mid-FETCH and make sure it stays dead.
        setCfg(6, 3, 1, 1, 2, 8, 100);
        applyStimulus();
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("abort_outputs",
            64'({o_valid, o_busy, o_done, o_last, o_sram_read_en, o_sram_read_addr, o_data_valid, o_data}), 64'd0);
        i_rst = 1'b0;
        readQ.delete();
        dc0 = doneCount;
        repeat (30) @(negedge i_clk);
        checkOutput("abort_no_reads", 64'(readQ.size()), 64'd0);
        checkOutput("abort_no_done", 64'(doneCount - dc0), 64'd0);
        checkOutput("abort_idle", {62'd0, o_valid, o_busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_window_router.md
Name: conv_window_router

Overview:
- Parametrised successor to the current input routing path.
- Fetches packed activation words from an external 1-cycle-latency SRAM read port and produces im2col convolution windows for ROW_COUNT output pixels in parallel.
- Generalised over runtime kernel size, stride, zero padding and channel count, with valid/ready output backpressure.
- Sits between the input SRAM and the systolic array row inputs, replacing the fixed 3x3, no-padding, no-backpressure routing path.

Parameters:
ROW_COUNT, 4, output rows (pixels processed per group)
DATA_WIDTH, 8, element width
SRAM_DATA_WIDTH, 64, SRAM word width; ELEMS = SRAM_DATA_WIDTH/DATA_WIDTH, power of two
ADDR_WIDTH, 10, SRAM address and size-field width
MAX_K, 7, largest kernel size supported by i_k_size

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  pulse; latches config and starts a job when idle, ignored when busy
i_start_addr  in  ADDR_WIDTH  word address of channel 0, element (0,0)
i_i_size  in  ADDR_WIDTH  input feature-map side length
i_o_size  in  ADDR_WIDTH  output feature-map side length
i_k_size  in  $clog2(MAX_K+1)  kernel side length, 1..MAX_K
i_stride  in  2  stride, 1..3
i_pad  in  2  zero-padding width, 0..3
i_channels  in  ADDR_WIDTH  channel count, >=1
i_plane_words  in  ADDR_WIDTH  word stride between channel planes
o_sram_read_en  out  1  SRAM read strobe
o_sram_read_addr  out  ADDR_WIDTH  SRAM read address
i_sram_data  in  SRAM_DATA_WIDTH  read data, valid exactly 1 cycle after o_sram_read_en
o_data  out  ROW_COUNT*DATA_WIDTH  one element per row
o_data_valid  out  ROW_COUNT  row mask; 0 for rows beyond the last output pixel
o_valid  out  1  beat valid
i_ready  in  1  consumer accepts the beat when o_valid & i_ready
o_last  out  1  last beat of the current pixel group
o_busy  out  1  job in progress
o_done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. i_rst has priority over all other inputs and aborts a job mid-flight. After an abort, no o_done pulse and no further reads.
- FSM states: IDLE -> FETCH -> CAPTURE -> EMIT -> {FETCH, DONE}; DONE -> IDLE.
- IDLE: on i_start, latch all config inputs and enter FETCH next cycle.
- Loop order, outermost first: pixel group g (pixels g*ROW_COUNT .. +ROW_COUNT-1, raster order), then channel c, then ky, then kx. Each (g,c,ky,kx) produces one beat.
- Per row r, the pixel is p = g*ROW_COUNT + r, with oy = p / o_size and ox = p % o_size.
  - iy = oy*stride + ky - pad; ix = ox*stride + kx - pad. Use signed arithmetic of at least ADDR_WIDTH+3 bits.
  - Use counters rather than dividers for these values.
- FETCH lasts exactly ROW_COUNT cycles; cycle r handles row r:
  - Row inactive (p >= o_size*o_size): no read; lane = 0; o_data_valid[r] = 0.
  - Row padded (iy or ix outside 0..i_size-1): no read; lane = 0; o_data_valid[r] = 1.
  - Otherwise: idx = iy*i_size + ix; assert o_sram_read_en with addr = start_addr + c*plane_words + (idx >> log2(ELEMS)), computed modulo 2^ADDR_WIDTH (wrap, no error).
  - Lane index is idx[log2(ELEMS)-1:0]; capture that lane of i_sram_data into row r on the following cycle.
- CAPTURE: one cycle that absorbs the read issued in the last FETCH cycle.
- EMIT: o_valid = 1. o_data, o_data_valid and o_last stay stable until accepted; no SRAM reads while waiting.
  - o_last = 1 when c, ky and kx are all at their maximum.
  - On acceptance, advance the counters and go to FETCH, or go to DONE if this was the final beat.
- Timing:
  - Latency from i_start to first o_valid: ROW_COUNT+2 cycles.
  - With i_ready held high, one beat every ROW_COUNT+2 cycles.
- DONE: o_done = 1 for one cycle; o_busy = 0 from the next cycle. o_busy is 1 in FETCH, CAPTURE and EMIT.
- Total beats = ceil(o_size^2/ROW_COUNT) * channels * k_size^2.
- Config values outside their stated ranges are undefined behaviour; not checked.

Test Plan:
- i_size=4, o_size=4, k=3, stride=1, pad=1, ch=1, start=0, element value = linear index+1:
  - beat 0 -> o_data all 0, o_data_valid=4'b1111.
  - beat 4 (ky=1, kx=1) -> o_data={1,2,3,4}.
  - 36 beats total; o_done pulses once after the 36th acceptance.
- i_size=5, o_size=3, k=3, pad=0 -> 3 groups; last group o_data_valid=4'b0001; 27 beats total.
- i_size=8, o_size=3, stride=2, k=3, pad=0 -> group 0 beat 0 reads pixels (0,0), (0,2), (0,4), (2,0) -> values {1,3,5,17}.
- ch=2, plane_words=2 -> channel-1 beats issue addresses offset by +2 from the matching channel-0 addresses.
- Backpressure: i_ready low for 5 cycles during EMIT -> o_data stable, o_sram_read_en=0 throughout. Reset pulse mid-FETCH -> all outputs 0 next cycle, no o_done.
